// File: rtl/host_link_pkg.sv
// host_link_pkg: shared definitions for the host link block.
//   host_state_t : session sequencer states
//   HOST_AW      : default dmem address / length width
package host_link_pkg;

    localparam int HOST_AW = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP,
        FIN
    } host_state_t;

endpackage

// File: rtl/host_link_wdog.sv
// host_wdog: RUN-phase cycle watchdog used by host_link when HOST_TIMEOUT_EN
// is defined.
//   clk, reset (async, active-low)
//   clr     : synchronous clear of the cycle count
//   en      : count this cycle
//   expired : high during the LIMIT-th enabled cycle since the last clear
module host_wdog #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Flagged combinationally on the final counted cycle so the owner can
    // leave its wait state on the same edge the limit is reached.
    assign expired = en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/host_link.sv
// host_link: host-side session sequencer for a small processor core.
// A session loads bytes from an inbound stream into dmem, releases the core
// until it reports done, then streams a dmem window back out.
//   clk, reset (async, active-low)
//   start                         : session request (IDLE only)
//   load_base/len, dump_base/len  : dmem windows, latched on start
//   s_valid/s_data/s_ready        : inbound byte stream
//   m_valid/m_data/m_ready        : outbound byte stream
//   dm_we/dm_addr/dm_di/dm_dout   : dmem port, combinational read
//   core_reset / core_done        : core hold and done flag
//   busy, session_done, timed_out : status
// Optional build macro HOST_TIMEOUT_EN adds a RUN-phase watchdog limited by
// TIMEOUT_CYCLES; without it timed_out is tied low and RUN waits forever.
module host_link
    import host_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned AW             = HOST_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] load_base,
    input  logic [AW-1:0] load_len,
    input  logic [AW-1:0] dump_base,
    input  logic [AW-1:0] dump_len,
    input  logic          s_valid,
    input  logic [7:0]    s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [7:0]    dm_di,
    input  logic [7:0]    dm_dout,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          session_done,
    output logic          timed_out
);

    host_state_t   state, state_nxt;
    logic [AW-1:0] idx;
    logic          arm;
    logic [AW-1:0] load_base_r, load_len_r, dump_base_r, dump_len_r;
    logic          expired;
    logic          run_exit;

`ifdef HOST_TIMEOUT_EN
    logic timed_out_r;

    host_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state != RUN),
        .en      (state == RUN),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timed_out_r <= 1'b0;
        end else if (state == IDLE && start) begin
            timed_out_r <= 1'b0;
        end else if (state == RUN && expired) begin
            timed_out_r <= 1'b1;
        end
    end

    assign timed_out = timed_out_r;
`else
    assign expired   = 1'b0;
    assign timed_out = 1'b0;
`endif

    // The core reports done while its PC is zero, i.e. straight out of
    // reset; only a done that follows an observed not-done ends RUN.
    assign run_exit = (arm && core_done) || expired;

    always_comb begin
        state_nxt    = state;
        s_ready      = 1'b0;
        m_valid      = 1'b0;
        m_data       = '0;
        dm_we        = 1'b0;
        dm_addr      = '0;
        dm_di        = '0;
        core_reset   = 1'b1;
        busy         = 1'b1;
        session_done = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (load_len != '0) ? LOAD : RUN;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                dm_addr = load_base_r + idx;
                dm_di   = s_data;
                dm_we   = s_valid;
                if (s_valid && idx == load_len_r - 1'b1) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                core_reset = 1'b0;
                if (run_exit) begin
                    state_nxt = (dump_len_r != '0) ? DUMP : FIN;
                end
            end
            DUMP: begin
                m_valid = 1'b1;
                dm_addr = dump_base_r + idx;
                m_data  = dm_dout;
                if (m_ready && idx == dump_len_r - 1'b1) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                session_done = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            arm         <= 1'b0;
            load_base_r <= '0;
            load_len_r  <= '0;
            dump_base_r <= '0;
            dump_len_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load_base_r <= load_base;
                        load_len_r  <= load_len;
                        dump_base_r <= dump_base;
                        dump_len_r  <= dump_len;
                        idx         <= '0;
                        arm         <= 1'b0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        idx <= idx + 1'b1;
                    end
                end
                RUN: begin
                    if (run_exit) begin
                        idx <= '0;
                        arm <= 1'b0;
                    end else if (!core_done) begin
                        arm <= 1'b1;
                    end
                end
                DUMP: begin
                    if (m_ready) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_link.sv
// tb_host_link: scoreboard bench for host_link. Each session pushes the
// expected dmem writes, outbound bytes and RUN length into queues; a monitor
// sampling on the falling edge pops and compares as the DUT presents them.
module tb_host_link;

    localparam int AW = 8;
`ifdef HOST_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 0;
`endif
    localparam int unsigned DUT_TO = (TO == 0) ? 4096 : TO;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] load_base = '0, load_len = '0, dump_base = '0, dump_len = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_ready = 1'b0;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [7:0]    dm_di;
    logic [7:0]    dm_dout;
    logic          core_reset;
    logic          core_done = 1'b1;
    logic          busy, session_done, timed_out;

    host_link #(.TIMEOUT_CYCLES(DUT_TO), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_base(load_base), .load_len(load_len),
        .dump_base(dump_base), .dump_len(dump_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_dout(dm_dout),
        .core_reset(core_reset), .core_done(core_done),
        .busy(busy), .session_done(session_done), .timed_out(timed_out)
    );

    always #5 clk = ~clk;

    // Environment dmem and the bench's own expectation of its contents.
    logic [7:0] dmem [256];
    logic [7:0] ref_mem [256];
    assign dm_dout = dmem[dm_addr];
    always @(posedge clk) if (dm_we) dmem[dm_addr] = dm_di;

    logic [15:0] wr_q [$];
    logic [15:0] rd_q [$];
    int          run_q [$];
    int          exp_done = 0, got_done = 0;
    int          checks = 0, errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor / scoreboard
    logic        prev_mv = 0, prev_mr = 0, prev_sd = 0;
    logic [7:0]  prev_md = 0;
    logic [7:0]  prev_ma = 0;
    int          run_len = 0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_mv = 0; prev_mr = 0; prev_sd = 0; run_len = 0;
        end else begin
            if (dm_we) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", dm_addr, dm_di);
                end else begin
                    logic [15:0] e;
                    e = wr_q.pop_front();
                    chk("wr_addr", dm_addr, e[15:8]);
                    chk("wr_data", dm_di, e[7:0]);
                end
            end
            if (m_valid) begin
                if (prev_mv && !prev_mr) begin
                    chk("hold_data", m_data, prev_md);
                    chk("hold_addr", dm_addr, prev_ma);
                end
                if (m_ready) begin
                    if (rd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_handshake: got data 0x%0h expected none", m_data);
                    end else begin
                        logic [15:0] e;
                        e = rd_q.pop_front();
                        chk("rd_addr", dm_addr, e[15:8]);
                        chk("rd_data", m_data, e[7:0]);
                    end
                end
            end
            if (session_done) begin
                got_done++;
                chk("done_single_cycle", prev_sd, 0);
            end
            if (busy && !core_reset) begin
                run_len++;
                chk("run_quiet", {s_ready, m_valid, dm_we, session_done}, 0);
            end else if (run_len > 0) begin
                if (run_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_run: got %0d cycles expected none", run_len);
                end else begin
                    chk("run_length", run_len, run_q.pop_front());
                end
                run_len = 0;
            end
            prev_mv = m_valid; prev_mr = m_ready; prev_md = m_data;
            prev_ma = dm_addr; prev_sd = session_done;
        end
    end

    task automatic session(input logic [7:0] lb, input logic [7:0] ll,
                           input logic [7:0] db, input logic [7:0] dl,
                           input int pre, input int work,
                           input bit nogap, input bit pat, input bit fixed);
        logic [7:0] bytes [$];
        logic [7:0] a, b;
        int rl, cyc, k, i;
        bit exp_to;
        for (int n = 0; n < int'(ll); n++) begin
            b = fixed ? 8'(8'h11 * (n + 1)) : 8'($urandom);
            a = lb + 8'(n);
            bytes.push_back(b);
            wr_q.push_back({a, b});
            ref_mem[a] = b;
        end
        for (int n = 0; n < int'(dl); n++) begin
            a = db + 8'(n);
            rd_q.push_back({a, ref_mem[a]});
        end
        rl = pre + work + 1;
        exp_to = (TO != 0) && (rl >= TO);
        if (exp_to) rl = TO;
        run_q.push_back(rl);
        exp_done++;

        @(posedge clk); #1;
        load_base = lb; load_len = ll; dump_base = db; dump_len = dl; start = 1;
        @(posedge clk); #1;
        start = 0;
        // Latched values must survive the inputs moving mid-session.
        load_base = 8'($urandom); load_len = 8'($urandom);
        dump_base = 8'($urandom); dump_len = 8'($urandom);

        i = 0; cyc = 0;
        while (i < int'(ll)) begin
            chk("load_ready", s_ready, 1);
            s_valid = nogap ? 1'b1 : ($urandom_range(0, 2) != 0);
            s_data  = bytes[i];
            start   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (s_valid) i++;
            cyc++;
            if (cyc > 200) begin
                checks++; errors++;
                $display("FAIL load_timeout: got %0d bytes expected %0d", i, ll);
                break;
            end
        end
        s_valid = 0; start = 0;
        if (nogap) chk("load_cycles", cyc, ll);

        chk("run_entry_core_reset", core_reset, 0);
        k = 0;
        while (!core_reset) begin
            core_done = (k < pre) ? 1'b1 : ((k < pre + work) ? 1'b0 : 1'b1);
            start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
            if (k > rl + 5) begin
                checks++; errors++;
                $display("FAIL run_timeout: got %0d cycles expected %0d", k, rl);
                break;
            end
        end
        core_done = 1; start = 0;
        chk("timed_out_after_run", timed_out, exp_to);

        k = 0;
        while (m_valid && k < 100) begin
            m_ready = pat ? 1'(k % 2) : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
        end
        m_ready = 0;
        if (pat) chk("dump_cycles", k, 2 * int'(dl));
        chk("fin_done", session_done, 1);
        @(posedge clk); #1;
        chk("idle_after_fin", {busy, session_done, core_reset}, 3'b001);
        chk("timed_out_sticky", timed_out, exp_to);
    endtask

    task automatic reset_mid_load();
        logic [7:0] lb, b0, b1;
        lb = 8'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
        wr_q.push_back({lb, b0});
        ref_mem[lb] = b0;
        @(posedge clk); #1;
        load_base = lb; load_len = 5; dump_base = 0; dump_len = 1; start = 1;
        @(posedge clk); #1;
        start = 0; s_valid = 1; s_data = b0;
        @(posedge clk); #1;
        s_data = b1;
        #2 reset = 0;
        #1;
        chk("abort_outputs", {busy, core_reset, dm_we, s_ready, session_done}, 5'b01000);
        repeat (2) @(posedge clk);
        #3 s_valid = 0;
        reset = 1;
        @(posedge clk); #1;
        chk("abort_idle", busy, 0);
        a_chk: chk("abort_no_write", dmem[lb + 8'd1], ref_mem[lb + 8'd1]);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int n = 0; n < 256; n++) begin
            dmem[n]    = 8'(n * 7 + 3);
            ref_mem[n] = 8'(n * 7 + 3);
        end
        #12;
        chk("reset_status", {busy, session_done, timed_out, core_reset}, 4'b0001);
        chk("reset_streams", {s_ready, m_valid, dm_we}, 0);
        chk("reset_buses", {dm_addr, dm_di, m_data}, 0);
        @(posedge clk); #3 reset = 1;

        session(8'h10, 3, 8'h10, 3, 1, 2, 1, 0, 1);
        session(8'hFE, 3, 8'hFE, 3, 0, 1, 1, 0, 0);
        session(8'h20, 0, 8'h10, 2, 2, 1, 0, 1, 0);
        session(8'h30, 2, 8'h30, 0, 0, 3, 0, 0, 0);
        session(8'h40, 1, 8'h40, 1, 1, 20, 0, 0, 0);
        reset_mid_load();
        for (int r = 0; r < 20; r++) begin
            session(8'($urandom), 8'($urandom_range(0, 6)),
                    8'($urandom), 8'($urandom_range(0, 6)),
                    $urandom_range(0, 3), $urandom_range(1, 6), 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("run_q_drained", run_q.size(), 0);
        chk("done_count", got_done, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_link.md
HOST_LINK -- requirements
Module: host_link

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the RUN-state cycle limit (used only with HOST_TIMEOUT_EN).
REQ-002 The module SHALL have parameter AW, default 8, meaning the dmem address and length width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  session request, sampled in IDLE only.
REQ-006 load_base, load_len  input  AW each  first dmem address and byte count to load.
REQ-007 dump_base, dump_len  input  AW each  first dmem address and byte count to read back.
REQ-008 s_valid, s_data[7:0]  input; s_ready  output  1 / 8 / 1  inbound byte stream.
REQ-009 m_valid, m_data[7:0]  output; m_ready  input  1 / 8 / 1  outbound byte stream.
REQ-010 dm_we  output 1, dm_addr  output AW, dm_di  output 8, dm_dout  input 8  dmem port; read data is combinational from dm_addr.
REQ-011 core_reset  output 1  active-high hold of the processor core.
REQ-012 core_done  input 1  processor done flag (high while the instruction pointer is zero).
REQ-013 busy, session_done, timed_out  output 1 each  status.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN, DUMP, FIN.
REQ-015 In IDLE with start=1, the module SHALL latch all base/len inputs, clear the byte index, and go to LOAD (load_len!=0) or RUN (load_len==0).
REQ-016 In LOAD, s_ready=1; per cycle with s_valid=1: dm_we=1, dm_addr=load_base+idx (mod 2^AW), dm_di=s_data, idx++; after byte load_len-1 -> RUN.
REQ-017 Outside LOAD: s_ready=0, dm_we=0.
REQ-018 core_reset SHALL be 1 in every state except RUN; it SHALL drop on the first RUN cycle.
REQ-019 RUN SHALL arm once core_done is sampled 0; an armed RUN with core_done=1 SHALL go to DUMP (dump_len!=0) or FIN, with idx cleared.
REQ-020 core_done=1 before arming SHALL be ignored, since the core reports done at PC 0.
REQ-021 In DUMP: m_valid=1, dm_addr=dump_base+idx, m_data=dm_dout.
REQ-022 In DUMP, m_data and dm_addr SHALL hold while m_ready=0; on m_valid&m_ready, idx++; after byte dump_len-1 -> FIN.
REQ-023 FIN SHALL last exactly one cycle with session_done=1, then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 Address arithmetic SHALL wrap modulo 2^AW; a length of 0 SHALL skip its phase.

Reset
REQ-027 reset=0 SHALL force asynchronously: state=IDLE, idx=0, arm=0, timeout count=0, core_reset=1, all other outputs 0.
REQ-028 Reset asserted mid-session SHALL abort it with no further dmem write, and no partial session_done.

Configuration
REQ-029 With HOST_TIMEOUT_EN defined, RUN SHALL count cycles; on reaching TIMEOUT_CYCLES it SHALL set timed_out=1 (sticky until the next start) and go to DUMP/FIN as in REQ-019.
REQ-030 Without HOST_TIMEOUT_EN, there SHALL be no counter, timed_out SHALL be tied 0, and RUN SHALL wait indefinitely.

Structure
REQ-031 The definitions package SHALL hold typedef host_state_t (the five states) and constant HOST_AW=8.
REQ-032 The timeout counter SHALL be sub-module host_wdog (inputs clk, reset, clr, en; output expired), instantiated only under HOST_TIMEOUT_EN.

Verification
REQ-033 Load 3 bytes 0x11,0x22,0x33 at load_base=0x10 with s_valid held 1 -> dmem[0x10..0x12] written on 3 consecutive cycles, then RUN.
REQ-034 load_base=0xFE, load_len=3 -> writes to 0xFE, 0xFF, 0x00.
REQ-035 core_done=1 for the first 2 RUN cycles, then 0, then 1 -> DUMP entered only after the 0->1 sequence; core_reset=0 throughout RUN.
REQ-036 dump_len=2 with m_ready toggling 0,1,0,1 -> each byte is held stable while stalled; exactly 2 handshakes; session_done pulses one cycle.
REQ-037 reset=0 asserted during LOAD byte 1 -> immediate IDLE, core_reset=1, no further dm_we.
REQ-038 With HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_done held 0 -> timed_out=1 after 16 RUN cycles, then DUMP proceeds.
